// File: rtl/dmem_arbiter_if.sv
// Signal bundle between the two requesters, the data-memory arbiter and the memory.
// slave is the arbiter's view; master is the combined requester/memory view.
interface dmem_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req0, req1;
    logic                  we0, we1;
    logic [1:0]            maskmode0, maskmode1;
    logic                  sext0, sext1;
    logic [DATA_WIDTH-1:0] addr0, addr1;
    logic [DATA_WIDTH-1:0] wdata0, wdata1;
    logic                  ack0, ack1;
    logic                  err0, err1;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  mem_write, mem_read;
    logic [1:0]            mem_maskmode;
    logic                  mem_sext;
    logic [DATA_WIDTH-1:0] mem_address, mem_write_data;
    logic [DATA_WIDTH-1:0] mem_read_data;

    modport slave (
        input  req0, req1, we0, we1, maskmode0, maskmode1, sext0, sext1,
               addr0, addr1, wdata0, wdata1, mem_read_data,
        output ack0, ack1, err0, err1, rdata,
               mem_write, mem_read, mem_maskmode, mem_sext, mem_address, mem_write_data
    );

    modport master (
        output req0, req1, we0, we1, maskmode0, maskmode1, sext0, sext1,
               addr0, addr1, wdata0, wdata1, mem_read_data,
        input  ack0, ack1, err0, err1, rdata,
               mem_write, mem_read, mem_maskmode, mem_sext, mem_address, mem_write_data
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the single-ported data memory (CPU LSU on port 0, loader on port 1).
// Define DMEM_ARB_FIXED_PRIO_EN for fixed port-0 priority; default is round-robin.
module dmem_arbiter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic           clk,
    input  logic           reset_n,
    dmem_arbiter_if.slave  bus
);
    typedef enum logic {ST_IDLE = 1'b0, ST_ACCESS = 1'b1} state_t;

    state_t                r_state, w_state_nxt;
    logic                  r_owner, r_we, r_sext, r_bad;
    logic [1:0]            r_mask;
    logic [DATA_WIDTH-1:0] r_addr, r_wdata, r_rdata;
    logic                  r_ack0, r_ack1, r_err0, r_err1;

    logic                  w_elig0, w_elig1, w_sel1, w_take;
    logic                  w_sel_we, w_sel_sext, w_sel_bad;
    logic [1:0]            w_sel_mask;
    logic [DATA_WIDTH-1:0] w_sel_addr, w_sel_wdata;
`ifndef DMEM_ARB_FIXED_PRIO_EN
    logic                  r_rr_ptr;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        // a port being acked this cycle is masked so a slow req drop is not re-served
        w_elig0     = bus.req0 & ~r_ack0;
        w_elig1     = bus.req1 & ~r_ack1;
`ifdef DMEM_ARB_FIXED_PRIO_EN
        w_sel1      = w_elig1 & ~w_elig0;
`else
        w_sel1      = w_elig1 & (~w_elig0 | r_rr_ptr);
`endif
        w_take      = (r_state == ST_IDLE) & (w_elig0 | w_elig1);
        w_sel_we    = w_sel1 ? bus.we1       : bus.we0;
        w_sel_mask  = w_sel1 ? bus.maskmode1 : bus.maskmode0;
        w_sel_sext  = w_sel1 ? bus.sext1     : bus.sext0;
        w_sel_addr  = w_sel1 ? bus.addr1     : bus.addr0;
        w_sel_wdata = w_sel1 ? bus.wdata1    : bus.wdata0;

        case (w_sel_mask)
            2'b00:   w_sel_bad = 1'b0;
            2'b01:   w_sel_bad = w_sel_addr[0];
            2'b10:   w_sel_bad = |w_sel_addr[1:0];
            default: w_sel_bad = 1'b1;
        endcase

        case (r_state)
            ST_IDLE:   if (w_take) w_state_nxt = ST_ACCESS;
            ST_ACCESS: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_owner  <= 1'b0;
            r_we     <= 1'b0;
            r_sext   <= 1'b0;
            r_bad    <= 1'b0;
            r_mask   <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;
            r_err0   <= 1'b0;
            r_err1   <= 1'b0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            r_rr_ptr <= 1'b0;
`endif
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            r_err0 <= 1'b0;
            r_err1 <= 1'b0;
            if (w_take) begin
                r_owner <= w_sel1;
                r_we    <= w_sel_we;
                r_mask  <= w_sel_mask;
                r_sext  <= w_sel_sext;
                r_addr  <= w_sel_addr;
                r_wdata <= w_sel_wdata;
                r_bad   <= w_sel_bad;
            end
            if (r_state == ST_ACCESS) begin
                // rdata only changes on loads so it survives intervening stores
                if (!r_we) r_rdata <= r_bad ? '0 : bus.mem_read_data;
                if (r_owner) begin
                    r_ack1 <= 1'b1;
                    r_err1 <= r_bad;
                end else begin
                    r_ack0 <= 1'b1;
                    r_err0 <= r_bad;
                end
`ifndef DMEM_ARB_FIXED_PRIO_EN
                r_rr_ptr <= ~r_owner;
`endif
            end
        end
    end

    assign bus.ack0           = r_ack0;
    assign bus.ack1           = r_ack1;
    assign bus.err0           = r_err0;
    assign bus.err1           = r_err1;
    assign bus.rdata          = r_rdata;
    assign bus.mem_write      = (r_state == ST_ACCESS) & r_we & ~r_bad;
    assign bus.mem_read       = (r_state == ST_ACCESS) & ~r_we & ~r_bad;
    assign bus.mem_maskmode   = r_mask;
    assign bus.mem_sext       = r_sext;
    assign bus.mem_address    = r_addr;
    assign bus.mem_write_data = r_wdata;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-addressed little-endian memory model
// (writes on negedge, combinational reads with byte/half/word and sign extension).
module tb_dmem_arbiter;
    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_errors;

    dmem_arbiter_if #(.DATA_WIDTH(32)) bus ();

    dmem_arbiter #(.DATA_WIDTH(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [7:0] mem [0:255];

    // preload then commit writes on the falling edge inside the access cycle
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'hEF; mem[8'h11] = 8'hBE; mem[8'h12] = 8'hAD; mem[8'h13] = 8'hDE;
        mem[8'h24] = 8'h0D; mem[8'h25] = 8'hF0; mem[8'h26] = 8'hFE; mem[8'h27] = 8'hCA;
        forever begin
            @(negedge clk);
            if (bus.mem_write) begin
                mem[bus.mem_address[7:0]] = bus.mem_write_data[7:0];
                if (bus.mem_maskmode != 2'b00)
                    mem[bus.mem_address[7:0] + 8'd1] = bus.mem_write_data[15:8];
                if (bus.mem_maskmode == 2'b10) begin
                    mem[bus.mem_address[7:0] + 8'd2] = bus.mem_write_data[23:16];
                    mem[bus.mem_address[7:0] + 8'd3] = bus.mem_write_data[31:24];
                end
            end
        end
    end

    logic [7:0] ma0, ma1, ma2, ma3;
    always_comb begin
        ma0 = bus.mem_address[7:0];
        ma1 = ma0 + 8'd1;
        ma2 = ma0 + 8'd2;
        ma3 = ma0 + 8'd3;
        case (bus.mem_maskmode)
            2'b00:   bus.mem_read_data = {{24{bus.mem_sext & mem[ma0][7]}}, mem[ma0]};
            2'b01:   bus.mem_read_data = {{16{bus.mem_sext & mem[ma1][7]}}, mem[ma1], mem[ma0]};
            default: bus.mem_read_data = {mem[ma3], mem[ma2], mem[ma1], mem[ma0]};
        endcase
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_p0(input logic r, input logic w, input logic [1:0] m, input logic s,
                          input logic [31:0] a, input logic [31:0] d);
        bus.req0 = r; bus.we0 = w; bus.maskmode0 = m; bus.sext0 = s; bus.addr0 = a; bus.wdata0 = d;
    endtask

    task automatic set_p1(input logic r, input logic w, input logic [1:0] m, input logic s,
                          input logic [31:0] a, input logic [31:0] d);
        bus.req1 = r; bus.we1 = w; bus.maskmode1 = m; bus.sext1 = s; bus.addr1 = a; bus.wdata1 = d;
    endtask

    logic [1:0] exp_acks [1:8];
    int         n_rd, n_ack;

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset_n  = 1'b0;
        set_p0(0, 0, 2'b00, 0, 32'h0, 32'h0);
        set_p1(0, 0, 2'b00, 0, 32'h0, 32'h0);
        #2;
        check_eq("rst_acks", {30'h0, bus.ack0, bus.ack1}, 32'h0);
        check_eq("rst_errs", {30'h0, bus.err0, bus.err1}, 32'h0);
        check_eq("rst_rdata", bus.rdata, 32'h0);
        check_eq("rst_strobes", {30'h0, bus.mem_write, bus.mem_read}, 32'h0);
        check_eq("rst_addr", bus.mem_address, 32'h0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // word load on port 0
        set_p0(1, 0, 2'b10, 0, 32'h10, 32'h0);
        tick();
        check_eq("ld_access_strobes", {30'h0, bus.mem_write, bus.mem_read}, 32'h1);
        check_eq("ld_access_addr", bus.mem_address, 32'h10);
        check_eq("ld_access_noack", {30'h0, bus.ack0, bus.ack1}, 32'h0);
        tick();
        check_eq("ld_ack", {30'h0, bus.ack0, bus.err0}, 32'h2);
        check_eq("ld_rdata", bus.rdata, 32'hDEADBEEF);
        check_eq("ld_ack_strobes", {30'h0, bus.mem_write, bus.mem_read}, 32'h0);
        bus.req0 = 1'b0;
        tick();
        check_eq("ld_ack_clears", {30'h0, bus.ack0, bus.ack1}, 32'h0);

        // byte store on port 1, then signed byte load back through port 0
        set_p1(1, 1, 2'b00, 0, 32'h21, 32'hAB);
        tick();
        check_eq("st_strobes", {30'h0, bus.mem_write, bus.mem_read}, 32'h2);
        check_eq("st_addr", bus.mem_address, 32'h21);
        check_eq("st_mask", {30'h0, bus.mem_maskmode}, 32'h0);
        check_eq("st_wdata", bus.mem_write_data, 32'hAB);
        tick();
        check_eq("st_ack", {30'h0, bus.ack1, bus.err1}, 32'h2);
        check_eq("st_rdata_held", bus.rdata, 32'hDEADBEEF);
        bus.req1 = 1'b0;
        set_p0(1, 0, 2'b00, 1, 32'h21, 32'h0);
        tick();
        check_eq("lb_strobes", {30'h0, bus.mem_write, bus.mem_read}, 32'h1);
        tick();
        check_eq("lb_ack", {30'h0, bus.ack0, bus.err0}, 32'h2);
        check_eq("lb_rdata", bus.rdata, 32'hFFFFFFAB);
        bus.req0 = 1'b0;
        tick();

        // last owner was port 0, so a simultaneous request goes to port 1 first
        set_p0(1, 0, 2'b10, 0, 32'h10, 32'h0);
        set_p1(1, 0, 2'b10, 0, 32'h24, 32'h0);
        tick();
        check_eq("rr_first_addr", bus.mem_address, 32'h24);
        tick();
        check_eq("rr_first_acks", {30'h0, bus.ack0, bus.ack1}, 32'h1);
        check_eq("rr_first_rdata", bus.rdata, 32'hCAFEF00D);
        bus.req1 = 1'b0;
        tick();
        check_eq("rr_second_addr", bus.mem_address, 32'h10);
        tick();
        check_eq("rr_second_acks", {30'h0, bus.ack0, bus.ack1}, 32'h2);
        check_eq("rr_second_rdata", bus.rdata, 32'hDEADBEEF);
        bus.req0 = 1'b0;
        tick();

        // both held from reset: grants alternate starting with port 0
        reset_n = 1'b0;
        set_p0(1, 0, 2'b10, 0, 32'h10, 32'h0);
        set_p1(1, 0, 2'b10, 0, 32'h24, 32'h0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        exp_acks[1] = 2'b00; exp_acks[2] = 2'b10; exp_acks[3] = 2'b00; exp_acks[4] = 2'b01;
        exp_acks[5] = 2'b00; exp_acks[6] = 2'b10; exp_acks[7] = 2'b00; exp_acks[8] = 2'b01;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check_eq($sformatf("alt_acks_%0d", k), {30'h0, bus.ack0, bus.ack1}, {30'h0, exp_acks[k]});
            if (k % 2 == 1)
                check_eq($sformatf("alt_addr_%0d", k), bus.mem_address, (k % 4 == 1) ? 32'h10 : 32'h24);
        end
        set_p0(0, 0, 2'b00, 0, 32'h0, 32'h0);
        set_p1(0, 0, 2'b00, 0, 32'h0, 32'h0);
        tick();
        check_eq("withdrawn_no_access", {30'h0, bus.mem_write, bus.mem_read}, 32'h0);
        tick();
        check_eq("withdrawn_no_ack", {30'h0, bus.ack0, bus.ack1}, 32'h0);

        // misaligned half store and reserved-mode load are rejected without strobes
        set_p0(1, 1, 2'b01, 0, 32'h13, 32'h5555);
        tick();
        check_eq("bad_st_strobes", {30'h0, bus.mem_write, bus.mem_read}, 32'h0);
        tick();
        check_eq("bad_st_ackerr", {30'h0, bus.ack0, bus.err0}, 32'h3);
        bus.req0 = 1'b0;
        tick();
        check_eq("bad_err_clears", {31'h0, bus.err0}, 32'h0);
        check_eq("bad_st_mem", {24'h0, mem[8'h13]}, 32'hDE);
        set_p0(1, 0, 2'b11, 0, 32'h0, 32'h0);
        tick();
        check_eq("bad_ld_strobes", {30'h0, bus.mem_write, bus.mem_read}, 32'h0);
        tick();
        check_eq("bad_ld_ackerr", {30'h0, bus.ack0, bus.err0}, 32'h3);
        check_eq("bad_ld_rdata", bus.rdata, 32'h0);
        bus.req0 = 1'b0;
        tick();

        // reset during a port-1 access cancels it; the held request is served afterwards
        set_p1(1, 0, 2'b10, 0, 32'h10, 32'h0);
        tick();
        check_eq("rstacc_strobe", {31'h0, bus.mem_read}, 32'h1);
        #2 reset_n = 1'b0;
        #1;
        check_eq("rstacc_strobes_now", {30'h0, bus.mem_write, bus.mem_read}, 32'h0);
        check_eq("rstacc_addr_now", bus.mem_address, 32'h0);
        tick();
        check_eq("rstacc_no_ack", {30'h0, bus.ack0, bus.ack1}, 32'h0);
        reset_n = 1'b1;
        tick();
        check_eq("rstacc_regrant", {31'h0, bus.mem_read}, 32'h1);
        tick();
        check_eq("rstacc_ack", {30'h0, bus.ack1, bus.err1}, 32'h2);
        check_eq("rstacc_rdata", bus.rdata, 32'hDEADBEEF);
        bus.req1 = 1'b0;
        tick();

        // requester keeps req high through its ack cycle: exactly one access
        set_p0(1, 0, 2'b10, 0, 32'h24, 32'h0);
        n_rd  = 0;
        n_ack = 0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            n_rd  += int'(bus.mem_read);
            n_ack += int'(bus.ack0);
            if (i == 3) bus.req0 = 1'b0;
        end
        check_eq("hold_reads", n_rd, 32'd1);
        check_eq("hold_acks", n_ack, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
